// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared mode encoding and parameter range check for count_mod
package count_pkg;

   typedef enum logic [1:0] {
      MODE_UP       = 2'd0,
      MODE_DOWN     = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_HOLD     = 2'd3
   } mode_t;

   // True when WIDTH >= 2, 1 <= MAX <= 2**WIDTH-1 and 0 <= RESET_VAL <= MAX.
   function automatic bit params_ok(input int width, input longint max_v, input longint reset_v);
      longint top;
      top = (longint'(1) << width) - 1;
      return (width >= 2) && (width <= 62) && (max_v >= 1) && (max_v <= top)
             && (reset_v >= 0) && (reset_v <= max_v);
   endfunction

endpackage

// File: rtl/count_mod_if.sv
// rtl/count_mod_if.sv - control and status bundle between a counter user and count_mod
interface count_mod_if
   import count_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             en;
   mode_t            mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             tc;

   modport master (
      output en, mode, load, load_val,
      input  count, dir, tc
   );

   modport slave (
      input  en, mode, load, load_val,
      output count, dir, tc
   );
endinterface

// File: rtl/count_mod_next.sv
// rtl/count_mod_next.sv - combinational next-count, next-direction and wrap flag
module count_mod_next
   import count_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH - 1
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             dir_i,
   input  mode_t            mode_i,
   output logic [WIDTH-1:0] next_count_o,
   output logic             next_dir_o,
   output logic             wrap_o
);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   always_comb begin
      next_count_o = count_i;
      next_dir_o   = dir_i;
      wrap_o       = 1'b0;
      unique case (mode_i)
         MODE_UP: begin
            next_dir_o = 1'b1;
            if (count_i >= MAX_V) begin
               next_count_o = ZERO_V;
               wrap_o       = 1'b1;
            end else begin
               next_count_o = count_i + ONE_V;
            end
         end
         MODE_DOWN: begin
            next_dir_o = 1'b0;
            if (count_i == ZERO_V) begin
               next_count_o = MAX_V;
               wrap_o       = 1'b1;
            end else begin
               next_count_o = count_i - ONE_V;
            end
         end
         MODE_PINGPONG: begin
            // The step leaving an endpoint reverses and counts as the wrap.
            if (dir_i) begin
               if (count_i >= MAX_V) begin
                  next_count_o = MAX_V - ONE_V;
                  next_dir_o   = 1'b0;
                  wrap_o       = 1'b1;
               end else begin
                  next_count_o = count_i + ONE_V;
               end
            end else begin
               if (count_i == ZERO_V) begin
                  next_count_o = ONE_V;
                  next_dir_o   = 1'b1;
                  wrap_o       = 1'b1;
               end else begin
                  next_count_o = count_i - ONE_V;
               end
            end
         end
         default: begin
            next_count_o = count_i;
            next_dir_o   = dir_i;
            wrap_o       = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/count_mod.sv
// rtl/count_mod.sv - modulo counter with up/down/ping-pong/hold modes, load and terminal-count pulse
module count_mod
   import count_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX       = 2**WIDTH - 1,
   parameter int RESET_VAL = 0
) (
   input  logic        clk,
   input  logic        reset,
   count_mod_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

   generate
      if (!params_ok(WIDTH, longint'(MAX), longint'(RESET_VAL))) begin : g_bad_params
         $error("count_mod: WIDTH, MAX or RESET_VAL out of range");
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] load_clamped;

   count_mod_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_next (
      .count_i      (count_q),
      .dir_i        (dir_q),
      .mode_i       (bus.mode),
      .next_count_o (count_d),
      .next_dir_o   (dir_d),
      .wrap_o       (tc_d)
   );

   assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_V;
         dir_q   <= 1'b1;
         tc_q    <= 1'b0;
      end else if (bus.load) begin
         count_q <= load_clamped;
         tc_q    <= 1'b0;
      end else if (bus.en && (bus.mode != MODE_HOLD)) begin
         count_q <= count_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
      end else begin
         tc_q    <= 1'b0;
      end
   end

   assign bus.count = count_q;
   assign bus.dir   = dir_q;
   assign bus.tc    = tc_q;
endmodule

// File: tb/tb_count_mod.sv
// tb/tb_count_mod.sv - scoreboard bench for count_mod with WIDTH=4, MAX=9, RESET_VAL=0
module tb_count_mod;
   import count_pkg::*;

   typedef struct {
      logic [3:0] c;
      logic       d;
      logic       t;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   drive_done = 1'b0;

   count_mod_if #(.WIDTH(4)) cif ();

   count_mod #(
      .WIDTH     (4),
      .MAX       (9),
      .RESET_VAL (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (cif.slave)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic ld, input logic e, input mode_t m,
                       input logic [3:0] lv, input int ec, input logic ed, input logic et,
                       input string nm);
      exp_t x;
      @(negedge clk);
      reset        = r;
      cif.load     = ld;
      cif.en       = e;
      cif.mode     = m;
      cif.load_val = lv;
      x.c = 4'(ec); x.d = ed; x.t = et; x.name = nm;
      sb_q.push_back(x);
      @(posedge clk);
   endtask

   task automatic do_reset(input string nm);
      step(1'b1, 1'b0, 1'b0, MODE_UP, 4'd0, 0, 1'b1, 1'b0, nm);
   endtask

   // Monitor: outputs are registered, so every edge presents a new response.
   always begin
      exp_t x;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         n_cmp++;
         if (cif.count !== x.c) begin
            n_bad++;
            $display("FAIL %s count: got %0d expected %0d", x.name, cif.count, x.c);
         end
         n_cmp++;
         if (cif.dir !== x.d) begin
            n_bad++;
            $display("FAIL %s dir: got %0b expected %0b", x.name, cif.dir, x.d);
         end
         n_cmp++;
         if (cif.tc !== x.t) begin
            n_bad++;
            $display("FAIL %s tc: got %0b expected %0b", x.name, cif.tc, x.t);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int up_c[11]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
      bit up_t[11]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      int dn_c[11]   = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
      bit dn_t[11]   = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      int pp_c[20]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      bit pp_d[20]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      bit pp_t[20]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

      reset = 1'b1; cif.en = 1'b0; cif.mode = MODE_UP; cif.load = 1'b0; cif.load_val = 4'd0;

      do_reset("s1_reset");
      for (int i = 0; i < 11; i++)
         step(1'b0, 1'b0, 1'b1, MODE_UP, 4'd0, up_c[i], 1'b1, up_t[i], $sformatf("s1_up[%0d]", i));
      step(1'b0, 1'b0, 1'b0, MODE_UP, 4'd0, 1, 1'b1, 1'b0, "s1_en_low");

      do_reset("s2_reset");
      for (int i = 0; i < 11; i++)
         step(1'b0, 1'b0, 1'b1, MODE_DOWN, 4'd0, dn_c[i], 1'b0, dn_t[i], $sformatf("s2_down[%0d]", i));

      do_reset("s3_reset");
      for (int i = 0; i < 20; i++)
         step(1'b0, 1'b0, 1'b1, MODE_PINGPONG, 4'd0, pp_c[i], pp_d[i], pp_t[i], $sformatf("s3_pp[%0d]", i));

      step(1'b0, 1'b1, 1'b0, MODE_HOLD, 4'd13, 9, 1'b1, 1'b0, "s4_load_clamp13");
      step(1'b0, 1'b1, 1'b1, MODE_UP,   4'd4,  4, 1'b1, 1'b0, "s4_load_wins");
      step(1'b0, 1'b1, 1'b0, MODE_UP,   4'd15, 9, 1'b1, 1'b0, "s4_load_clamp15");
      step(1'b0, 1'b1, 1'b0, MODE_UP,   4'd9,  9, 1'b1, 1'b0, "s4_load_max");

      do_reset("s5_reset");
      for (int i = 1; i <= 6; i++)
         step(1'b0, 1'b0, 1'b1, MODE_UP, 4'd0, i, 1'b1, 1'b0, $sformatf("s5_up[%0d]", i));
      step(1'b0, 1'b0, 1'b1, MODE_DOWN, 4'd0, 5, 1'b0, 1'b0, "s5_down");
      step(1'b1, 1'b1, 1'b1, MODE_UP, 4'd7, 0, 1'b1, 1'b0, "s5_reset_wins");

      for (int i = 1; i <= 5; i++)
         step(1'b0, 1'b0, 1'b1, MODE_UP, 4'd0, i, 1'b1, 1'b0, $sformatf("s6_up[%0d]", i));
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, MODE_UP, 4'd0, 5, 1'b1, 1'b0, $sformatf("s6_en_low[%0d]", i));
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b0, 1'b1, MODE_HOLD, 4'd0, 5, 1'b1, 1'b0, $sformatf("s6_hold[%0d]", i));
      step(1'b0, 1'b0, 1'b1, MODE_PINGPONG, 4'd0, 6, 1'b1, 1'b0, "s6_pp_a");
      step(1'b0, 1'b0, 1'b1, MODE_PINGPONG, 4'd0, 7, 1'b1, 1'b0, "s6_pp_b");

      do_reset("s7_reset");
      step(1'b0, 1'b0, 1'b1, MODE_DOWN,     4'd0, 9, 1'b0, 1'b1, "s7_down_wrap");
      step(1'b0, 1'b0, 1'b1, MODE_PINGPONG, 4'd0, 8, 1'b0, 1'b0, "s7_pp_keeps_dir");
      step(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 4'd0, 0, 1'b0, 1'b0, "s7_load_keeps_dir");
      step(1'b0, 1'b0, 1'b1, MODE_PINGPONG, 4'd0, 1, 1'b1, 1'b1, "s7_pp_reverse_low");
      step(1'b0, 1'b0, 1'b0, MODE_PINGPONG, 4'd0, 1, 1'b1, 1'b0, "s7_tc_clears");

      @(negedge clk);
      drive_done = 1'b1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
